// File: rtl/bist_stim_misr.sv
// bist_stim_misr
//   Built-in self-test driver and checker for an 8-bit registered-input test design.
//   Each start pulse runs one self-test: the block holds the DUT in reset, feeds it a
//   run of LFSR patterns, folds the DUT responses into a 16-bit MISR signature, then
//   compares that signature with a golden value.
//
// Ports
//   clk         in   1   single clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   run request, only honoured in IDLE
//   abort       in   1   stop the current run and return to IDLE without a done pulse
//   golden_sig  in  16   expected signature, sampled in DONE
//   resp_in     in   8   DUT data_out
//   stim_out    out  8   DUT data_in (registered LFSR state)
//   dut_rst     out  1   active-high DUT reset (registered)
//   busy        out  1   high in RESET_DUT, RUN and DRAIN
//   done        out  1   one-cycle pulse when a run completes
//   pass        out  1   signature matched golden_sig; held until the next start
//   signature   out 16   MISR value; held until the next start
module bist_stim_misr #(
    parameter int unsigned N_PATTERNS = 256,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RST_CYCLES = 2,
    parameter logic [7:0]  SEED       = 8'h01,
    parameter logic [15:0] MISR_POLY  = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden_sig,
    input  logic [7:0]  resp_in,
    output logic [7:0]  stim_out,
    output logic        dut_rst,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int unsigned MAX_NL  = (N_PATTERNS > LATENCY) ? N_PATTERNS : LATENCY;
    localparam int unsigned MAX_CNT = (MAX_NL > RST_CYCLES) ? MAX_NL : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RESET_DUT = 3'd1;
    localparam logic [2:0] RUN       = 3'd2;
    localparam logic [2:0] DRAIN     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length)
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] fb;
        fb = s[15] ? MISR_POLY : 16'h0000;
        return ({s[14:0], 1'b0} ^ fb) ^ {8'h00, d};
    endfunction

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [15:0]        sig_q, sig_d;
    logic               pass_q, pass_d;
    logic               dut_rst_q, dut_rst_d;
    logic               is_busy;

    assign is_busy = (state_q == RESET_DUT) || (state_q == RUN) || (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        // vld_q[k] marks that the pattern driven k+1 cycles ago was a RUN pattern, so the
        // top bit lines resp_in up with the stimulus that produced it.
        vld_d   = LATENCY'({vld_q, (state_q == RUN)});

        if (vld_q[LATENCY-1]) begin
            sig_d = misr_step(sig_q, resp_in);
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start && !abort) begin
                    state_d = RESET_DUT;
                    lfsr_d  = SEED;
                    sig_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RESET_DUT: begin
                lfsr_d = SEED;
                if (cnt_q == RST_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (cnt_q == RUN_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                // The last MISR update landed at the end of DRAIN, so sig_q is final here.
                pass_d  = (sig_q == golden_sig);
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort drops the run; the response already in flight this cycle still lands in
        // the signature, but everything queued behind it is discarded.
        if (abort && is_busy) begin
            state_d = IDLE;
            cnt_d   = '0;
            vld_d   = '0;
            pass_d  = 1'b0;
        end

        dut_rst_d = (state_d == RESET_DUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            vld_q     <= '0;
            sig_q     <= '0;
            pass_q    <= 1'b0;
            dut_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            vld_q     <= vld_d;
            sig_q     <= sig_d;
            pass_q    <= pass_d;
            dut_rst_q <= dut_rst_d;
        end
    end

    assign stim_out  = lfsr_q;
    assign dut_rst   = dut_rst_q;
    assign busy      = is_busy;
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule

// File: tb/tb_bist_stim_misr.sv
// tb_bist_stim_misr
//   Bench for bist_stim_misr. Six instances cover the parameter points of interest:
//   0: N=8   L=2 (basic run, abort, ignored starts, async reset)
//   1: N=1   L=2 with resp_in=FF
//   2: N=2   L=2 with resp_in=FF
//   3: N=256 L=2 loopback through a 2-cycle delay
//   4: N=256 L=1 loopback through a 1-cycle delay
//   5: N=256 L=3 loopback through a 3-cycle delay
//   The driver pushes the expected signature/pass of each completed run into a queue;
//   the monitor pops an entry whenever any instance pulses done.
module tb_bist_stim_misr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_v   [6];
    logic        abort0;
    logic [15:0] golden_v  [6];
    logic [7:0]  resp8;
    logic [7:0]  stim_v    [6];
    logic        dut_rst_v [6];
    logic        busy_v    [6];
    logic        done_v    [6];
    logic        pass_v    [6];
    logic [15:0] sig_v     [6];

    // loopback delay lines: resp in cycle c = stim in cycle c-L
    logic [7:0] d3_0, d3_1;
    logic [7:0] d4_0;
    logic [7:0] d5_0, d5_1, d5_2;
    always @(posedge clk) begin
        d3_0 <= stim_v[3];
        d3_1 <= d3_0;
        d4_0 <= stim_v[4];
        d5_0 <= stim_v[5];
        d5_1 <= d5_0;
        d5_2 <= d5_1;
    end

    bist_stim_misr #(.N_PATTERNS(8), .LATENCY(2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort0), .golden_sig(golden_v[0]),
        .resp_in(resp8), .stim_out(stim_v[0]), .dut_rst(dut_rst_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]));
    bist_stim_misr #(.N_PATTERNS(1), .LATENCY(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(1'b0), .golden_sig(golden_v[1]),
        .resp_in(8'hFF), .stim_out(stim_v[1]), .dut_rst(dut_rst_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]));
    bist_stim_misr #(.N_PATTERNS(2), .LATENCY(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(1'b0), .golden_sig(golden_v[2]),
        .resp_in(8'hFF), .stim_out(stim_v[2]), .dut_rst(dut_rst_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .pass(pass_v[2]), .signature(sig_v[2]));
    bist_stim_misr #(.N_PATTERNS(256), .LATENCY(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .abort(1'b0), .golden_sig(golden_v[3]),
        .resp_in(d3_1), .stim_out(stim_v[3]), .dut_rst(dut_rst_v[3]), .busy(busy_v[3]),
        .done(done_v[3]), .pass(pass_v[3]), .signature(sig_v[3]));
    bist_stim_misr #(.N_PATTERNS(256), .LATENCY(1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .abort(1'b0), .golden_sig(golden_v[4]),
        .resp_in(d4_0), .stim_out(stim_v[4]), .dut_rst(dut_rst_v[4]), .busy(busy_v[4]),
        .done(done_v[4]), .pass(pass_v[4]), .signature(sig_v[4]));
    bist_stim_misr #(.N_PATTERNS(256), .LATENCY(3)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start_v[5]), .abort(1'b0), .golden_sig(golden_v[5]),
        .resp_in(d5_2), .stim_out(stim_v[5]), .dut_rst(dut_rst_v[5]), .busy(busy_v[5]),
        .done(done_v[5]), .pass(pass_v[5]), .signature(sig_v[5]));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        logic [15:0] sig;
        logic        pass;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] seq8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference signature: LFSR patterns from seed 01 folded straight into the MISR.
    function automatic logic [15:0] ref_sig(input int n);
        logic [7:0]  s;
        logic [15:0] m;
        s = 8'h01;
        m = 16'h0000;
        for (int k = 0; k < n; k++) begin
            m = (m << 1) ^ (m[15] ? 16'h1021 : 16'h0000) ^ {8'h00, s};
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        return m;
    endfunction

    task automatic start_run(input int i, input logic push, input logic [15:0] esig,
                             input logic epass);
        exp_t e;
        if (push) begin
            e.inst = i;
            e.sig  = esig;
            e.pass = epass;
            exp_q.push_back(e);
        end
        @(posedge clk); #1 start_v[i] = 1'b1;
        @(posedge clk); #1 start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done_v[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[i]) chk($sformatf("timeout_inst%0d", i), 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Inst 0 with resp_in=0: 2 reset cycles, 8 patterns, 2 drain cycles, done, signature 0.
    task automatic run_t1(input logic glitch);
        resp8 = 8'h00;
        golden_v[0] = 16'h0000;
        start_run(0, 1'b1, 16'h0000, 1'b1);
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            chk("t1_dut_rst", dut_rst_v[0], c < 2);
            chk("t1_busy", busy_v[0], (c < 12));
            chk("t1_done", done_v[0], c == 12);
            if (c < 2) chk("t1_stim_seed", stim_v[0], 8'h01);
            if (c >= 2 && c < 10) chk($sformatf("t1_stim_%0d", c - 2), stim_v[0], seq8[c-2]);
            start_v[0] = glitch && (c == 5 || c == 12);
        end
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_all(input string tag);
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_stim"}, stim_v[i], 8'h01);
            chk({tag, "_dut_rst"}, dut_rst_v[i], 1'b0);
            chk({tag, "_busy"}, busy_v[i], 1'b0);
            chk({tag, "_done"}, done_v[i], 1'b0);
            chk({tag, "_pass"}, pass_v[i], 1'b0);
            chk({tag, "_sig"}, sig_v[i], 16'h0000);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation; pass is
    // checked the cycle after done, once DONE has latched the comparison.
    initial begin
        exp_t e;
        logic pend;
        logic pend_pass;
        int   pend_i;
        pend = 1'b0;
        pend_pass = 1'b0;
        pend_i = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk($sformatf("sb_pass_inst%0d", pend_i), pass_v[pend_i], pend_pass);
                pend = 1'b0;
            end
            for (int i = 0; i < 6; i++) begin
                if (done_v[i]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("unexpected_done_inst%0d", i), 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_inst", i, e.inst);
                        chk($sformatf("sb_sig_inst%0d", i), sig_v[i], e.sig);
                        chk($sformatf("sb_busy_in_done_inst%0d", i), busy_v[i], 1'b0);
                        pend = 1'b1;
                        pend_pass = e.pass;
                        pend_i = i;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r256;
        bit seen;
        for (int i = 0; i < 6; i++) begin
            start_v[i]  = 1'b0;
            golden_v[i] = 16'h0000;
        end
        abort0 = 1'b0;
        resp8  = 8'h00;
        r256   = ref_sig(256);

        #12;
        chk_reset_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic run
        run_t1(1'b0);

        // single and double pattern signatures
        golden_v[1] = 16'h00FF;
        start_run(1, 1'b1, 16'h00FF, 1'b1);
        wait_done(1, 50);
        golden_v[2] = 16'h0101;
        start_run(2, 1'b1, 16'h0101, 1'b1);
        wait_done(2, 50);

        // 256-pattern loopback, matching and off-by-one-bit golden
        golden_v[3] = r256;
        start_run(3, 1'b1, r256, 1'b1);
        wait_done(3, 400);
        golden_v[3] = r256 ^ 16'h0001;
        start_run(3, 1'b1, r256, 1'b0);
        wait_done(3, 400);

        // other latencies give the same signature
        golden_v[4] = r256;
        start_run(4, 1'b1, r256, 1'b1);
        wait_done(4, 400);
        golden_v[5] = r256;
        start_run(5, 1'b1, r256, 1'b1);
        wait_done(5, 400);

        // abort during RUN cycle 5
        resp8 = 8'hFF;
        start_run(0, 1'b0, 16'h0000, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("abort_pre_stim", stim_v[0], seq8[5]);
        chk("abort_pre_busy", busy_v[0], 1'b1);
        abort0 = 1'b1;
        @(posedge clk); #1 abort0 = 1'b0;
        chk("abort_busy", busy_v[0], 1'b0);
        chk("abort_dut_rst", dut_rst_v[0], 1'b0);
        chk("abort_pass", pass_v[0], 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) seen = 1'b1;
        end
        chk("abort_stays_idle", seen, 1'b0);

        // starts during RUN and DONE are ignored
        run_t1(1'b1);

        // asynchronous reset mid-run
        resp8 = 8'hFF;
        start_run(0, 1'b0, 16'h0000, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_reset_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // same run as the first after reset
        run_t1(1'b0);

        repeat (4) @(negedge clk);
        chk("sb_all_done_seen", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
